// File: rtl/dsp_seq_pkg.sv
// dsp_seq_pkg: shared opcodes, ALU/mux encodings and FSM state types for dsp_sequencer.
package dsp_seq_pkg;
    typedef enum logic [1:0] {S_EXEC, S_OPERAND, S_HALT} state_t;
    typedef enum logic [1:0] {BR_B, BR_BZ, BR_CALL} br_t;
    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [1:0] AIN_SHIFT = 2'd0;
    localparam logic [1:0] AIN_P = 2'd1;
    localparam logic [1:0] AIN_SEXT = 2'd2;
    localparam logic [2:0] ACC_ALU = 3'd0;
    localparam logic [2:0] ACC_SHIFT = 3'd1;
    localparam logic [2:0] ACC_P = 3'd2;
    localparam logic [2:0] ACC_ROM = 3'd4;
    localparam logic [2:0] ACC_STACK = 3'd5;
    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_LAC = 4'h2;
    localparam logic [7:0] OP_LT = 8'h6A;
    localparam logic [7:0] OP_MPY = 8'h6D;
    localparam logic [7:0] OP_LACK = 8'h7E;
    localparam logic [2:0] OP_MPYK = 3'b100;
    localparam logic [15:0] OP_PAC = 16'h7F8E;
    localparam logic [15:0] OP_APAC = 16'h7F8F;
    localparam logic [15:0] OP_PUSH = 16'h7F9C;
    localparam logic [15:0] OP_POP = 16'h7F9D;
    localparam logic [15:0] OP_RET = 16'h7F8D;
    localparam logic [15:0] OP_NOP = 16'h7F80;
    localparam logic [15:0] OP_B = 16'hF900;
    localparam logic [15:0] OP_BZ = 16'hFF00;
    localparam logic [15:0] OP_CALL = 16'hF800;
endpackage

// File: rtl/dsp_sequencer_stack.sv
// dsp_stack: DEPTH-level shift-register hardware stack.
// Ports: clk_i, rst_ni (async active-low), push_i/din_i shift down (bottom lost),
//        pop_i shifts up (bottom duplicated), top_o = entry 0 (pre-pop during a pop).
module dsp_stack #(
    parameter int PC_W  = 12,
    parameter int DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] din_i,
    output logic [PC_W-1:0] top_o
);
    logic [PC_W-1:0] stk_q [DEPTH];
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
        end else if (push_i) begin
            stk_q[0] <= din_i;
            for (int i = 1; i < DEPTH; i++) stk_q[i] <= stk_q[i-1];
        end else if (pop_i) begin
            for (int i = 0; i < DEPTH - 1; i++) stk_q[i] <= stk_q[i+1];
        end
    end
    assign top_o = stk_q[0];
endmodule

// File: rtl/dsp_sequencer.sv
// dsp_sequencer: TMS32010-style instruction decoder, next-PC logic and 4-level stack.
// Ports: clk_i, rst_ni (async active-low); pc_i/instr_i current fetch; acc_zero_i,
//        acc_low_i (PUSH source); pc_next_o, stack_top_o; datapath selects alu_shift_o,
//        alu_in_sel_o, alu_cmd_o, acc_in_sel_o, mult_in_sel_o; enables t_en_o, p_en_o,
//        acc_en_o; halted_o.
// Option: define DSP_SEQ_ILLEGAL_TRAP_EN to halt on undefined opcodes (else they act as NOP).
module dsp_sequencer
    import dsp_seq_pkg::*;
#(
    parameter int PC_W        = 12,
    parameter int STACK_DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [PC_W-1:0] pc_i,
    input  logic [15:0]     instr_i,
    input  logic            acc_zero_i,
    input  logic [PC_W-1:0] acc_low_i,
    output logic [PC_W-1:0] pc_next_o,
    output logic [PC_W-1:0] stack_top_o,
    output logic [3:0]      alu_shift_o,
    output logic [1:0]      alu_in_sel_o,
    output logic [2:0]      alu_cmd_o,
    output logic [2:0]      acc_in_sel_o,
    output logic            mult_in_sel_o,
    output logic            t_en_o,
    output logic            p_en_o,
    output logic            acc_en_o,
    output logic            halted_o
);
    state_t          state_q, state_d;
    br_t             br_q, br_d;
    logic            push, pop;
    logic [PC_W-1:0] din, pc_inc;
    assign pc_inc = pc_i + 1'b1;
    dsp_stack #(.PC_W(PC_W), .DEPTH(STACK_DEPTH)) u_stack (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (push),
        .pop_i  (pop),
        .din_i  (din),
        .top_o  (stack_top_o)
    );
    // Outputs are forced quiet while reset is held, independent of instr_i.
    always_comb begin
        state_d       = state_q;
        br_d          = br_q;
        pc_next_o     = pc_inc;
        push          = 1'b0;
        pop           = 1'b0;
        din           = pc_inc;
        alu_shift_o   = '0;
        alu_in_sel_o  = AIN_SHIFT;
        alu_cmd_o     = ALU_ADD;
        acc_in_sel_o  = ACC_ALU;
        mult_in_sel_o = 1'b0;
        t_en_o        = 1'b0;
        p_en_o        = 1'b0;
        acc_en_o      = 1'b0;
        if (!rst_ni) begin
            pc_next_o = '0;
        end else if (state_q == S_OPERAND) begin
            // instr_i is the branch target word; CALL pushes the address after it
            pc_next_o = (br_q != BR_BZ || acc_zero_i) ? instr_i[PC_W-1:0] : pc_inc;
            push      = (br_q == BR_CALL);
            state_d   = S_EXEC;
        end else if (state_q == S_HALT) begin
            pc_next_o = pc_i;
        end else if (instr_i[15:12] == OP_ADD || instr_i[15:12] == OP_SUB) begin
            alu_shift_o = instr_i[11:8];
            alu_cmd_o   = instr_i[12] ? ALU_SUB : ALU_ADD;
            acc_en_o    = 1'b1;
        end else if (instr_i[15:12] == OP_LAC) begin
            alu_shift_o  = instr_i[11:8];
            acc_in_sel_o = ACC_SHIFT;
            acc_en_o     = 1'b1;
        end else if (instr_i[15:8] == OP_LT) begin
            t_en_o = 1'b1;
        end else if (instr_i[15:8] == OP_MPY) begin
            p_en_o = 1'b1;
        end else if (instr_i[15:13] == OP_MPYK) begin
            mult_in_sel_o = 1'b1;
            p_en_o        = 1'b1;
        end else if (instr_i[15:8] == OP_LACK) begin
            acc_in_sel_o = ACC_ROM;
            acc_en_o     = 1'b1;
        end else if (instr_i == OP_PAC) begin
            acc_in_sel_o = ACC_P;
            acc_en_o     = 1'b1;
        end else if (instr_i == OP_APAC) begin
            alu_in_sel_o = AIN_P;
            acc_en_o     = 1'b1;
        end else if (instr_i == OP_PUSH) begin
            push = 1'b1;
            din  = acc_low_i;
        end else if (instr_i == OP_POP) begin
            pop          = 1'b1;
            acc_in_sel_o = ACC_STACK;
            acc_en_o     = 1'b1;
        end else if (instr_i == OP_RET) begin
            pop       = 1'b1;
            pc_next_o = stack_top_o;
        end else if (instr_i == OP_B || instr_i == OP_BZ || instr_i == OP_CALL) begin
            br_d    = instr_i == OP_B ? BR_B : instr_i == OP_BZ ? BR_BZ : BR_CALL;
            state_d = S_OPERAND;
`ifdef DSP_SEQ_ILLEGAL_TRAP_EN
        end else if (instr_i != OP_NOP) begin
            state_d   = S_HALT;
            pc_next_o = pc_i;
`endif
        end
    end
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_EXEC;
            br_q    <= BR_B;
        end else begin
            state_q <= state_d;
            br_q    <= br_d;
        end
    end
`ifdef DSP_SEQ_ILLEGAL_TRAP_EN
    assign halted_o = (state_q == S_HALT);
`else
    assign halted_o = 1'b0;
`endif
endmodule

// File: tb/tb_dsp_sequencer.sv
// tb_dsp_sequencer: directed scoreboard bench for dsp_sequencer.
module tb_dsp_sequencer;
    typedef struct packed {
        logic [11:0] pcn;
        logic [11:0] top;
        logic [3:0]  sh;
        logic [1:0]  ain;
        logic [2:0]  cmd;
        logic [2:0]  asel;
        logic        msel;
        logic        t;
        logic        p;
        logic        a;
        logic        h;
    } exp_t;
    logic        clk = 1'b0, rst_n = 1'b0, acc_zero = 1'b0;
    logic [11:0] pc = '0, acc_low = '0;
    logic [15:0] instr = '0;
    logic [11:0] pc_next, stack_top;
    logic [3:0]  alu_shift;
    logic [1:0]  alu_in_sel;
    logic [2:0]  alu_cmd, acc_in_sel;
    logic        mult_in_sel, t_en, p_en, acc_en, halted;
    exp_t        exp_q[$];
    string       name_q[$];
    exp_t        act, e;
    string       n;
    int          tests = 0, fails = 0;
    int          pop_top[5] = '{5, 4, 3, 2, 2};
    always #5 clk = ~clk;
    dsp_sequencer dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .pc_i         (pc),
        .instr_i      (instr),
        .acc_zero_i   (acc_zero),
        .acc_low_i    (acc_low),
        .pc_next_o    (pc_next),
        .stack_top_o  (stack_top),
        .alu_shift_o  (alu_shift),
        .alu_in_sel_o (alu_in_sel),
        .alu_cmd_o    (alu_cmd),
        .acc_in_sel_o (acc_in_sel),
        .mult_in_sel_o(mult_in_sel),
        .t_en_o       (t_en),
        .p_en_o       (p_en),
        .acc_en_o     (acc_en),
        .halted_o     (halted)
    );
    assign act = {pc_next, stack_top, alu_shift, alu_in_sel, alu_cmd, acc_in_sel,
                  mult_in_sel, t_en, p_en, acc_en, halted};
    function automatic exp_t mk(int pcn, int top, int sh, int ain, int cmd, int asel,
                                int msel, int t, int p, int a, int h);
        mk.pcn  = 12'(pcn);
        mk.top  = 12'(top);
        mk.sh   = 4'(sh);
        mk.ain  = 2'(ain);
        mk.cmd  = 3'(cmd);
        mk.asel = 3'(asel);
        mk.msel = msel[0];
        mk.t    = t[0];
        mk.p    = p[0];
        mk.a    = a[0];
        mk.h    = h[0];
    endfunction
    task automatic step(input string nm, input logic r, input logic [11:0] p,
                        input logic [15:0] ins, input logic az, input logic [11:0] al,
                        input exp_t ex);
        @(posedge clk);
        #1;
        rst_n    = r;
        pc       = p;
        instr    = ins;
        acc_zero = az;
        acc_low  = al;
        exp_q.push_back(ex);
        name_q.push_back(nm);
    endtask
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            tests++;
            if (act !== e) begin
                fails++;
                $display("FAIL %s: got pcn=%h top=%h sh=%h ain=%h cmd=%h asel=%h msel=%b t=%b p=%b a=%b h=%b; want pcn=%h top=%h sh=%h ain=%h cmd=%h asel=%h msel=%b t=%b p=%b a=%b h=%b",
                         n, act.pcn, act.top, act.sh, act.ain, act.cmd, act.asel, act.msel, act.t, act.p, act.a, act.h,
                         e.pcn, e.top, e.sh, e.ain, e.cmd, e.asel, e.msel, e.t, e.p, e.a, e.h);
            end
        end
    end
    initial begin
        step("reset", 1'b0, 12'h000, 16'h0300, 1'b0, 12'h0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("add", 1'b1, 12'h000, 16'h0300, 1'b0, 12'h0, mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
        step("sub", 1'b1, 12'h001, 16'h1500, 1'b0, 12'h0, mk(2, 0, 5, 0, 1, 0, 0, 0, 0, 1, 0));
        step("lac", 1'b1, 12'h002, 16'h2700, 1'b0, 12'h0, mk(3, 0, 7, 0, 0, 1, 0, 0, 0, 1, 0));
        step("lt", 1'b1, 12'h003, 16'h6A12, 1'b0, 12'h0, mk(4, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        step("mpy", 1'b1, 12'h004, 16'h6D00, 1'b0, 12'h0, mk(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        step("b", 1'b1, 12'h005, 16'hF900, 1'b0, 12'h0, mk(6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("b_op", 1'b1, 12'h006, 16'h0123, 1'b0, 12'h0, mk('h123, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("mpyk", 1'b1, 12'h123, 16'h8ABC, 1'b0, 12'h0, mk('h124, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));
        step("lack", 1'b1, 12'h124, 16'h7E55, 1'b0, 12'h0, mk('h125, 0, 0, 0, 0, 4, 0, 0, 0, 1, 0));
        step("pac", 1'b1, 12'h125, 16'h7F8E, 1'b0, 12'h0, mk('h126, 0, 0, 0, 0, 2, 0, 0, 0, 1, 0));
        step("apac", 1'b1, 12'h126, 16'h7F8F, 1'b0, 12'h0, mk('h127, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0));
        step("bz_nt", 1'b1, 12'h127, 16'hFF00, 1'b0, 12'h0, mk('h128, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("bz_nt_op", 1'b1, 12'h128, 16'h0400, 1'b0, 12'h0, mk('h129, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("bz_t", 1'b1, 12'h129, 16'hFF00, 1'b1, 12'h0, mk('h12A, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("bz_t_op", 1'b1, 12'h12A, 16'h0050, 1'b1, 12'h0, mk('h050, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("call", 1'b1, 12'h010, 16'hF800, 1'b0, 12'h0, mk('h011, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("call_op", 1'b1, 12'h011, 16'h0200, 1'b0, 12'h0, mk('h200, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("nop_sub", 1'b1, 12'h200, 16'h7F80, 1'b0, 12'h0, mk('h201, 'h012, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("ret", 1'b1, 12'h201, 16'h7F8D, 1'b0, 12'h0, mk('h012, 'h012, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("after_ret", 1'b1, 12'h012, 16'h7F80, 1'b0, 12'h0, mk('h013, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("wrap", 1'b1, 12'hFFF, 16'h7F80, 1'b0, 12'h0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++)
            step($sformatf("push%0d", i), 1'b1, 12'(32 + i - 1), 16'h7F9C, 1'b0, 12'(i),
                 mk(33 + i - 1, i - 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 5; k++)
            step($sformatf("pop%0d", k), 1'b1, 12'(37 + k), 16'h7F9D, 1'b0, 12'h0,
                 mk(38 + k, pop_top[k], 0, 0, 0, 5, 0, 0, 0, 1, 0));
        step("call2", 1'b1, 12'h030, 16'hF800, 1'b0, 12'h0, mk('h031, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("rst_mid", 1'b0, 12'h031, 16'h0300, 1'b0, 12'h0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("rel_exec", 1'b1, 12'h000, 16'h0040, 1'b0, 12'h0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
`ifdef DSP_SEQ_ILLEGAL_TRAP_EN
        step("illegal", 1'b1, 12'h001, 16'h7FFF, 1'b0, 12'h0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("halted", 1'b1, 12'h001, 16'h0300, 1'b0, 12'h0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
`else
        step("illegal", 1'b1, 12'h001, 16'h7FFF, 1'b0, 12'h0, mk(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("after_ill", 1'b1, 12'h002, 16'h0300, 1'b0, 12'h0, mk(3, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
`endif
        step("rst_end", 1'b0, 12'h001, 16'h0300, 1'b0, 12'h0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        step("post_rst", 1'b1, 12'h000, 16'h0300, 1'b0, 12'h0, mk(1, 0, 3, 0, 0, 0, 0, 0, 0, 1, 0));
        repeat (4) @(negedge clk);
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expected entries left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
